// File: rtl/instruction_prefetch_unit_if.sv
// rtl/instruction_prefetch_unit_if.sv - fetch, redirect and decode-side signal bundle of the prefetch unit
interface instruction_prefetch_unit_if #(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  // instruction memory request / response
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_instr;

  // control from the pipeline
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;

  // decode-side queue head
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_instr;
  logic [CW-1:0]   queue_count;

  // the prefetch unit itself
  modport master (
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_pc_plus4, out_instr, queue_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_instr,
    input  redirect_valid, redirect_pc, stall, out_ready
  );

  // memory, pipeline control and decode around it
  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_pc_plus4, out_instr, queue_count,
    output imem_req_ready, imem_resp_valid, imem_resp_instr,
    output redirect_valid, redirect_pc, stall, out_ready
  );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// rtl/instruction_prefetch_unit.sv - single-outstanding instruction prefetcher with a small fetch queue
module instruction_prefetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QUEUE_DEPTH  = 4
) (
  input logic                         clk,
  input logic                         reset,
  instruction_prefetch_unit_if.master bus
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  // FETCH may issue, WAIT has a live request out, DRAIN owes a response that must be dropped
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] redirect_target;

  logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];
  logic [XLEN-1:0] q_instr [QUEUE_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            req_fire;
  logic            enq;
  logic            deq;
  logic            not_empty;

  // low two target bits are masked rather than sliced so every input bit is consumed
  assign redirect_target = bus.redirect_pc & ~XLEN'(3);
  assign not_empty       = (count != '0);

  // handshake and queue events; redirect suppresses both enqueue and dequeue
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign enq      = (state == S_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
  assign deq      = bus.out_valid && bus.out_ready && !bus.stall;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: any response closes the outstanding request, redirect without one leaves it to be drained
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (req_fire) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          state_nxt = S_FETCH;
        end else if (bus.redirect_valid) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.imem_resp_valid) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // outputs: request gated by stall, redirect and free slot; head fields read as zero when empty
  always_comb begin
    bus.imem_req_valid = (state == S_FETCH) && !bus.stall && !bus.redirect_valid &&
                         (count < CW'(QUEUE_DEPTH));
    bus.imem_req_addr  = fetch_pc;
    bus.out_valid      = not_empty && !bus.redirect_valid;
    bus.out_pc         = '0;
    bus.out_pc_plus4   = '0;
    bus.out_instr      = '0;
    if (not_empty) begin
      bus.out_pc       = q_pc[rd_ptr];
      bus.out_pc_plus4 = q_pc[rd_ptr] + XLEN'(4);
      bus.out_instr    = q_instr[rd_ptr];
    end
    bus.queue_count    = count;
  end

  // fetch address: redirect wins, otherwise advance one word per accepted request
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_VECTOR;
      req_pc   <= RESET_VECTOR;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (req_fire) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // queue pointers and occupancy; flush on reset or redirect
  always_ff @(posedge clk) begin
    if (!reset || bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (enq && !deq) begin
        count <= count + CW'(1);
      end else if (!enq && deq) begin
        count <= count - CW'(1);
      end
    end
  end

  // queue storage, written with the pc of the request that produced the response
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      q_pc[wr_ptr]    <= req_pc;
      q_instr[wr_ptr] <= bus.imem_resp_instr;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// tb/tb_instruction_prefetch_unit.sv - directed and randomized self-checking bench for instruction_prefetch_unit
module tb_instruction_prefetch_unit;

  localparam int XLEN = 32;
  localparam int QD   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  instruction_prefetch_unit_if #(.XLEN(XLEN), .QUEUE_DEPTH(QD)) bus ();

  instruction_prefetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .QUEUE_DEPTH  (QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: contents of the fetch queue, fetch address and the outstanding-request bookkeeping
  entry_t      mq[$];
  bit          m_valid   = 0;
  bit          m_out     = 0;
  bit          m_discard = 0;
  logic [31:0] m_fetch_pc = 0;
  logic [31:0] m_req_pc   = 0;

  // memory model: one pending request, fixed or random latency
  bit          mem_busy  = 0;
  int          mem_cnt   = 0;
  logic [31:0] mem_instr = 0;
  int          mem_lat_fixed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit stl, input bit rdv, input logic [31:0] rpc,
                      input bit ordy, input bit rdy_en);
    bit          e_req;
    bit          e_outv;
    bit          fire;
    bit          deq;
    bit          rsp;
    int          n;
    entry_t      e;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    @(negedge clk);
    rsp                  = mem_busy && (mem_cnt == 0);
    reset                = rst_n;
    bus.stall            = stl;
    bus.redirect_valid   = rdv;
    bus.redirect_pc      = rpc;
    bus.out_ready        = ordy;
    bus.imem_req_ready   = rdy_en && !mem_busy;
    bus.imem_resp_valid  = rsp;
    bus.imem_resp_instr  = rsp ? mem_instr : $urandom;
    #1;
    n      = mq.size();
    e_req  = m_valid && !m_out && !stl && !rdv && (n < QD);
    e_outv = (n != 0) && !rdv;
    e_pc    = (n != 0) ? mq[0].pc : 32'h0;
    e_instr = (n != 0) ? mq[0].instr : 32'h0;
    if (m_valid) begin
      chk("req_valid",    {31'b0, bus.imem_req_valid}, {31'b0, e_req});
      chk("req_addr",     bus.imem_req_addr, m_fetch_pc);
      chk("out_valid",    {31'b0, bus.out_valid}, {31'b0, e_outv});
      chk("queue_count",  {29'b0, bus.queue_count}, n);
      chk("out_pc",       bus.out_pc, e_pc);
      chk("out_pc_plus4", bus.out_pc_plus4, (n != 0) ? e_pc + 32'd4 : 32'h0);
      chk("out_instr",    bus.out_instr, e_instr);
    end
    fire = e_req && bus.imem_req_ready;
    if (!rst_n) begin
      mq.delete();
      m_out      = 0;
      m_discard  = 0;
      m_fetch_pc = 32'h0;
      m_valid    = 1;
    end else if (m_valid) begin
      if (rdv) begin
        mq.delete();
        m_fetch_pc = rpc & ~32'h3;
        if (m_out) begin
          if (rsp) begin
            m_out     = 0;
            m_discard = 0;
          end else begin
            m_discard = 1;
          end
        end
      end else begin
        deq = e_outv && ordy && !stl;
        if (deq) void'(mq.pop_front());
        if (m_out && rsp) begin
          if (!m_discard) begin
            e.pc    = m_req_pc;
            e.instr = mem_instr;
            mq.push_back(e);
          end
          m_out     = 0;
          m_discard = 0;
        end
        if (fire) begin
          m_out      = 1;
          m_req_pc   = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
    if (rsp) begin
      mem_busy = 0;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    if (fire) begin
      mem_busy  = 1;
      mem_cnt   = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 3));
      mem_instr = $urandom;
    end
  endtask

  initial begin
    logic [31:0] rpc;
    reset               = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_instr = '0;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // first cycle after reset release issues the reset vector
    step(1, 0, 0, 0, 0, 1);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("rst_req_addr",  bus.imem_req_addr, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_count",     {29'b0, bus.queue_count}, 32'd0);
    repeat (7) step(1, 0, 0, 0, 0, 1);

    // queue full: no more requests
    step(1, 0, 0, 0, 0, 1);
    chk("full_count",     {29'b0, bus.queue_count}, 32'd4);
    chk("full_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("full_head_pc",   bus.out_pc, 32'h0);
    chk("full_head_pc4",  bus.out_pc_plus4, 32'h4);

    // one dequeue frees a slot, next request is 16
    step(1, 0, 0, 0, 1, 1);
    chk("deq_head_pc", bus.out_pc, 32'h0);
    step(1, 0, 0, 0, 0, 1);
    chk("refill_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("refill_addr",      bus.imem_req_addr, 32'd16);
    chk("refill_head_pc",   bus.out_pc, 32'h4);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("refill_count", {29'b0, bus.queue_count}, 32'd4);

    // redirect while waiting on a slow response: response dropped, refetch aligned target
    step(1, 0, 1, 32'h0000_0200, 0, 1);
    mem_lat_fixed = 2;
    step(1, 0, 0, 0, 0, 1);
    chk("pre_wait_addr", bus.imem_req_addr, 32'h200);
    step(1, 0, 1, 32'h0000_0103, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("drain_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("drain_count", {29'b0, bus.queue_count}, 32'd0);
    mem_lat_fixed = 0;
    step(1, 0, 0, 0, 0, 1);
    chk("post_drain_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("post_drain_addr",      bus.imem_req_addr, 32'h100);
    chk("post_drain_count",     {29'b0, bus.queue_count}, 32'd0);

    // redirect in the same cycle as a response with decode ready
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("pre_redir_count", {29'b0, bus.queue_count}, 32'd1);
    step(1, 0, 1, 32'h0000_0300, 1, 1);
    chk("redir_out_valid", {31'b0, bus.out_valid}, 32'd0);
    step(1, 0, 0, 0, 1, 1);
    chk("redir_count", {29'b0, bus.queue_count}, 32'd0);
    chk("redir_addr",  bus.imem_req_addr, 32'h300);

    // stall holds two queued entries and blocks issue
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    repeat (3) begin
      step(1, 1, 0, 0, 1, 1);
      chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      chk("stall_count",     {29'b0, bus.queue_count}, 32'd2);
    end
    step(1, 0, 0, 0, 0, 1);
    chk("post_stall_head", bus.out_pc, 32'h300);

    // wrap of pc+4 and fetch address at the top of the address space
    step(1, 0, 1, 32'hFFFF_FFFC, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("wrap_issue_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("wrap_out_pc",    bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_out_pc4",   bus.out_pc_plus4, 32'h0);
    chk("wrap_next_addr", bus.imem_req_addr, 32'h0);

    // randomized traffic against the model
    mem_lat_fixed = -1;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0,
           rpc, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_unit.md
INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/instruction width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter QUEUE_DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-006 imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  XLEN  fetch address, always word-aligned.
REQ-009 imem_resp_valid  input  1  instruction return for the single outstanding request.
REQ-010 imem_resp_instr  input  XLEN  returned instruction word.
REQ-011 redirect_valid  input  1  jump/branch taken; flush and refetch.
REQ-012 redirect_pc  input  XLEN  redirect target; bits [1:0] ignored and treated as 00.
REQ-013 stall  input  1  global hold (data-memory busywait); blocks issue and dequeue.
REQ-014 out_valid  output  1  queue head valid to decode.
REQ-015 out_ready  input  1  decode consumes head.
REQ-016 out_pc / out_pc_plus4 / out_instr  output  XLEN each  head entry PC, PC+4, instruction.
REQ-017 queue_count  output  $clog2(QUEUE_DEPTH)+1  current occupancy.

Function
REQ-018 FSM states: FETCH (may issue), WAIT (one request outstanding), DRAIN (outstanding response to be discarded).
REQ-019 At most one outstanding memory request at any time.
REQ-020 imem_req_valid = (state==FETCH) && !stall && !redirect_valid && (queue_count < QUEUE_DEPTH); imem_req_addr = fetch_pc.
REQ-021 Request handshake at edge with imem_req_valid && imem_req_ready: fetch_pc <= fetch_pc + 4 (mod 2^XLEN), FETCH -> WAIT.
REQ-022 In WAIT, imem_resp_valid enqueues {pc_of_request, imem_resp_instr}, WAIT -> FETCH; slot guaranteed by REQ-020.
REQ-023 out_valid = (queue_count != 0) && !redirect_valid; dequeue occurs at edge with out_valid && out_ready && !stall.
REQ-024 Simultaneous enqueue and dequeue: count unchanged, both take effect; FIFO order preserved; read/write pointers wrap modulo QUEUE_DEPTH.
REQ-025 out_pc_plus4 = out_pc + 4, wrapping modulo 2^XLEN; outputs registered-from-queue, zero when empty.
REQ-026 redirect_valid has priority over all other events in that cycle: queue flushed (count 0), fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, no enqueue, no dequeue.
REQ-027 Redirect in FETCH or in WAIT with imem_resp_valid same cycle: next state FETCH; that response is discarded.
REQ-028 Redirect in WAIT without response: next state DRAIN; the next imem_resp_valid is discarded, DRAIN -> FETCH.
REQ-029 Redirect in DRAIN: stays DRAIN (or FETCH if response arrives that cycle); fetch_pc updated to newest target.
REQ-030 stall holds queue and fetch_pc; responses during stall still enqueue; states WAIT/DRAIN still progress on imem_resp_valid.
REQ-031 imem_resp_valid in FETCH is ignored.

Reset
REQ-032 reset==0 at posedge: state FETCH, fetch_pc=RESET_VECTOR, pointers and queue_count 0, out_valid 0, outputs 0; overrides redirect and responses.
REQ-033 Reset mid-WAIT: outstanding response after reset release is ignored (state FETCH per REQ-031).
REQ-034 First cycle after reset release with stall=0: imem_req_valid=1, imem_req_addr=RESET_VECTOR.

Verification
REQ-035 Reset release, ready=1, 1-cycle response, out_ready=0 -> addresses 0,4,8,12 issued, queue_count reaches 4, imem_req_valid then 0.
REQ-036 Full queue, out_ready=1 for one cycle -> head pc 0 consumed, next request addr 16 issued, count returns to 4.
REQ-037 Redirect to 0x0000_0103 while WAIT, response 2 cycles later -> queue empty, response discarded, next request addr 0x0000_0100.
REQ-038 Redirect same cycle as response and out_ready=1 -> no enqueue, no dequeue, count 0, next addr = target.
REQ-039 stall=1 for 3 cycles with 2 entries queued and out_ready=1 -> no issue, no dequeue, count held at 2 (plus any pending response).
REQ-040 Redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC, out_pc_plus4 0x0000_0000, next fetch addr 0x0000_0000.
